// File: rtl/draw_arbiter.sv
// Round-robin arbiter that lends the VGA pixel port to one drawing client at a time.
// A grant lasts until that client raises done or a timeout expires. One release cycle follows each grant.
module draw_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int TIMEOUT   = 16383
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [35:0] x_in,
  input  logic [35:0] y_in,
  input  logic [11:0] colour_in,
  input  logic [3:0]  done_in,
  output logic [3:0]  draw_en,
  output logic [8:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAW    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [13:0] TIMEOUT_LAST = 14'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [3:0]  draw_en_q, draw_en_d;
  logic [8:0]  vga_x_q, vga_x_d;
  logic [8:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [13:0] cnt_q, cnt_d;
  logic        first_q, first_d;

  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic [8:0]  cur_x;
  logic [8:0]  cur_y;
  logic [2:0]  cur_colour;
  logic        cur_done;

  // Search order starts one past the last grant; the last grant itself is checked last.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      idx = last_grant_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    cur_x      = x_in[8:0];
    cur_y      = y_in[8:0];
    cur_colour = colour_in[2:0];
    cur_done   = done_in[0];
    case (grant_q)
      2'd1: begin
        cur_x      = x_in[17:9];
        cur_y      = y_in[17:9];
        cur_colour = colour_in[5:3];
        cur_done   = done_in[1];
      end
      2'd2: begin
        cur_x      = x_in[26:18];
        cur_y      = y_in[26:18];
        cur_colour = colour_in[8:6];
        cur_done   = done_in[2];
      end
      2'd3: begin
        cur_x      = x_in[35:27];
        cur_y      = y_in[35:27];
        cur_colour = colour_in[11:9];
        cur_done   = done_in[3];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    draw_en_d    = draw_en_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    first_d      = first_q;

    case (state_q)
      S_IDLE: begin
        draw_en_d = '0;
        if (found) begin
          grant_d      = pick;
          last_grant_d = pick;
          draw_en_d    = 4'b0001 << pick;
          cnt_d        = '0;
          first_d      = 1'b1;
          state_d      = S_DRAW;
        end
      end
      S_DRAW: begin
        vga_x_d      = cur_x;
        vga_y_d      = cur_y;
        vga_colour_d = cur_colour;
        cnt_d        = cnt_q + 14'd1;
        first_d      = 1'b0;
        // Done wins over a timeout landing in the same cycle.
        if (cur_done) begin
          draw_en_d = '0;
          state_d   = S_RELEASE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          draw_en_d = '0;
          err_d     = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          // Client coordinates trail its enable by a cycle, so the first sample is stale.
          vga_plot_d = !first_q;
        end
      end
      S_RELEASE: begin
        draw_en_d = '0;
        state_d   = S_IDLE;
      end
      default: begin
        draw_en_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'd3;
      draw_en_q    <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      draw_en_q    <= draw_en_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
    end
  end

  assign draw_en     = draw_en_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign timeout_err = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: each task models the granted client at the negedge
// and checks registered outputs inline against hand-derived expectations.
module tb_draw_arbiter;

  localparam int TIMEOUT = 16383;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [35:0] x_in, y_in;
  logic [11:0] colour_in;
  logic [3:0]  done_in;
  logic [3:0]  draw_en;
  logic [8:0]  vga_x, vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, timeout_err;
  logic [1:0]  grant_id, dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  draw_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .done_in(done_in), .draw_en(draw_en),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Pixel p of any client: {x, y, colour}; x never 0 and y never 0.
  function automatic logic [20:0] pix(input int p);
    return {9'(10 + p % 9), 9'(20 + (p / 9) % 100), 3'(p % 8)};
  endfunction

  // Client c in its k-th DRAW cycle: stale zeros at k=0, pixels 0..npix-1, then done.
  task automatic drive_client(input int c, input int k, input int npix);
    logic [20:0] v;
    v = (k == 0) ? 21'd0 : pix(k - 1);
    x_in      = {4{9'h155}};
    y_in      = {4{9'h0aa}};
    colour_in = {4{3'b101}};
    x_in[9*c +: 9]      = v[20:12];
    y_in[9*c +: 9]      = v[11:3];
    colour_in[3*c +: 3] = v[2:0];
    done_in = 4'b1111 & ~(4'b0001 << c);
    if (k == npix + 1) done_in[c] = 1'b1;
  endtask

  task automatic expect_grant(input int c, input string tag);
    @(negedge clk);
    total_cnt++;
    if ({draw_en, grant_id, busy, dbg_state} !== {4'(1 << c), 2'(c), 1'b1, ST_DRAW})
      $display("FAIL %s grant: draw_en=%b grant_id=%0d busy=%b state=%0d, want draw_en=%b grant_id=%0d busy=1 state=1",
               tag, draw_en, grant_id, busy, dbg_state, 4'(1 << c), c);
    else pass_cnt++;
  endtask

  task automatic run_burst(input int c, input int npix, input string tag);
    logic exp_plot;
    logic [3:0] exp_en;
    logic [20:0] exp_pix;
    for (int k = 0; k <= npix + 1; k++) begin
      drive_client(c, k, npix);
      @(negedge clk);
      exp_plot = (k >= 1 && k <= npix);
      exp_en   = (k == npix + 1) ? 4'b0000 : 4'(1 << c);
      total_cnt++;
      if ({draw_en, grant_id, vga_plot} !== {exp_en, 2'(c), exp_plot})
        $display("FAIL %s k=%0d: draw_en=%b grant_id=%0d plot=%b, want %b %0d %b",
                 tag, k, draw_en, grant_id, vga_plot, exp_en, c, exp_plot);
      else pass_cnt++;
      if (exp_plot) begin
        exp_pix = pix(k - 1);
        total_cnt++;
        if ({vga_x, vga_y, vga_colour} !== exp_pix)
          $display("FAIL %s pixel k=%0d: x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d", tag, k,
                   vga_x, vga_y, vga_colour, exp_pix[20:12], exp_pix[11:3], exp_pix[2:0]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({dbg_state, busy} !== {ST_REL, 1'b1})
      $display("FAIL %s release: state=%0d busy=%b, want 2 1", tag, dbg_state, busy);
    else pass_cnt++;
    done_in = 4'b0000;
    @(negedge clk);
    total_cnt++;
    if ({dbg_state, busy, draw_en, vga_plot} !== {ST_IDLE, 1'b0, 4'b0000, 1'b0})
      $display("FAIL %s idle: state=%0d busy=%b draw_en=%b plot=%b, want 0 0 0000 0",
               tag, dbg_state, busy, draw_en, vga_plot);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 4'b1111; done_in = 4'b1111;
    x_in = '1; y_in = '1; colour_in = '1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({draw_en, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout_err, dbg_state} !== 32'd0)
      $display("FAIL reset outputs: en=%b x=%0d y=%0d c=%0d plot=%b busy=%b gid=%0d err=%b st=%0d, want all 0",
               draw_en, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout_err, dbg_state);
    else pass_cnt++;
    req = 4'b0000; done_in = 4'b0000;
    resetn = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({draw_en, vga_plot, busy, dbg_state} !== {4'b0000, 1'b0, 1'b0, ST_IDLE})
        $display("FAIL idle hold %0d: draw_en=%b plot=%b busy=%b state=%0d, want 0000 0 0 0",
                 i, draw_en, vga_plot, busy, dbg_state);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    expect_grant(0, "single");
    req = 4'b0000;
    run_burst(0, 81, "single");
  endtask

  task automatic test_round_robin();
    test_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_grant(g % 4, "rr");
      run_burst(g % 4, 3, "rr");
    end
    req = 4'b0000;
  endtask

  task automatic test_first_cycle();
    req = 4'b0100;
    expect_grant(2, "first_cycle");
    req = 4'b0000;
    run_burst(2, 5, "first_cycle");
  endtask

  task automatic test_coincidence();
    req = 4'b0010;
    expect_grant(1, "coincide");
    req = 4'b0000;
    run_burst(1, TIMEOUT - 2, "coincide");
    total_cnt++;
    if (timeout_err !== 1'b0)
      $display("FAIL coincide err: timeout_err=%b, want 0", timeout_err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    expect_grant(1, "timeout");
    req = 4'b0000;
    for (int k = 0; k < TIMEOUT; k++) begin
      drive_client(1, k, TIMEOUT + 10);
      @(negedge clk);
      if (k == TIMEOUT - 2) begin
        total_cnt++;
        if ({draw_en, timeout_err} !== {4'b0010, 1'b0})
          $display("FAIL timeout early: draw_en=%b err=%b, want 0010 0", draw_en, timeout_err);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({draw_en, timeout_err, vga_plot, dbg_state} !== {4'b0000, 1'b1, 1'b0, ST_REL})
      $display("FAIL timeout abort: draw_en=%b err=%b plot=%b state=%0d, want 0000 1 0 2",
               draw_en, timeout_err, vga_plot, dbg_state);
    else pass_cnt++;
    done_in = 4'b0000;
    @(negedge clk);
    req = 4'b0010;
    expect_grant(1, "after_timeout");
    req = 4'b0000;
    run_burst(1, 2, "after_timeout");
    total_cnt++;
    if (timeout_err !== 1'b1)
      $display("FAIL sticky err: timeout_err=%b, want 1", timeout_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b1000;
    expect_grant(3, "mid_reset");
    for (int k = 0; k <= 30; k++) begin
      drive_client(3, k, 81);
      @(negedge clk);
    end
    total_cnt++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, pix(29)})
      $display("FAIL mid_reset pixel29: plot=%b x=%0d y=%0d c=%0d", vga_plot, vga_x, vga_y, vga_colour);
    else pass_cnt++;
    drive_client(3, 31, 81);
    resetn = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({draw_en, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout_err, dbg_state} !== 32'd0)
      $display("FAIL mid_reset outputs: en=%b x=%0d y=%0d c=%0d plot=%b busy=%b gid=%0d err=%b st=%0d, want all 0",
               draw_en, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout_err, dbg_state);
    else pass_cnt++;
    resetn = 1'b1;
    done_in = 4'b0000;
    expect_grant(3, "regrant");
    run_burst(3, 4, "regrant");
    req = 4'b1001;
    expect_grant(0, "after_regrant");
    req = 4'b0000;
    run_burst(0, 2, "after_regrant");
  endtask

  initial begin
    resetn = 1'b0; req = '0; x_in = '0; y_in = '0; colour_in = '0; done_in = '0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_first_cycle();
    test_coincidence();
    test_timeout();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
